// File: rtl/screen_pkg.sv
// Shared constants and FSM state type for the character-screen write path.
package screen_pkg;
  localparam int DEF_SCREEN_ADDRESS_WIDTH = 15;
  localparam int DEF_SLOT_COUNT           = 32400;
  localparam int DEF_DATA_WIDTH           = 7;

  localparam logic [6:0] SPACE       = 7'h20;
  localparam logic [6:0] PRINT_FIRST = 7'h20;
  localparam int         PRINT_SPAN  = 95;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: combinational head read, registered occupancy count.
// Push when full and pop when empty are the caller's responsibility to avoid.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/screen_write_sched.sv
// Screen BRAM port-A scheduler: FIFO'd UART writes vs. full-screen clear sweep, one write per cycle.
// Write reaches BRAM 2 cycles after handshake; SCREEN_FILL_PATTERN_EN swaps FILL_CHAR for a printable-ASCII ramp.
module screen_write_sched
  import screen_pkg::*;
#(
  parameter int SCREEN_ADDRESS_WIDTH = DEF_SCREEN_ADDRESS_WIDTH,
  parameter int SLOT_COUNT           = DEF_SLOT_COUNT,
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH           = 4,
  parameter logic [DATA_WIDTH-1:0] FILL_CHAR = DATA_WIDTH'(SPACE)
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [SCREEN_ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            clr_start,
  output logic                            clr_busy,
  output logic                            clr_done,
  output logic                            bad_addr,
  output logic                            bram_wen,
  output logic [SCREEN_ADDRESS_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]           bram_data
);
  localparam int FW = SCREEN_ADDRESS_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                          r_state;
  logic [SCREEN_ADDRESS_WIDTH-1:0] r_cnt;
  logic                            r_wr_ready;
  logic                            r_clr_busy;
  logic                            r_clr_done;
  logic                            r_bad_addr;
  logic                            r_bram_wen;
  logic [SCREEN_ADDRESS_WIDTH-1:0] r_bram_addr;
  logic [DATA_WIDTH-1:0]           r_bram_data;

  logic                            w_accept;
  logic                            w_in_range;
  logic                            w_push;
  logic                            w_pop;
  logic                            w_fifo_full;
  logic                            w_fifo_empty;
  logic                            w_almost_full;
  logic                            w_ready_next;
  logic [CW-1:0]                   w_fifo_count;
  logic [FW-1:0]                   w_fifo_dout;
  logic [SCREEN_ADDRESS_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0]           w_head_data;
  logic                            w_last;
  logic [DATA_WIDTH-1:0]           w_fill_first;
  logic [DATA_WIDTH-1:0]           w_fill_next;

  assign w_accept   = wr_valid && r_wr_ready;
  assign w_in_range = ({1'b0, wr_addr} < (SCREEN_ADDRESS_WIDTH+1)'(SLOT_COUNT));
  assign w_push     = w_accept && w_in_range;
  assign w_pop      = (r_state == IDLE) && !clr_start && !w_fifo_empty;
  assign w_last     = (r_cnt == SCREEN_ADDRESS_WIDTH'(SLOT_COUNT - 1));

  // Ready is registered from the next-cycle occupancy, so a pop never frees a slot in the same cycle.
  assign w_almost_full = (w_fifo_count == CW'(FIFO_DEPTH - 1));
  assign w_ready_next  = !((w_fifo_full && !w_pop) || (w_almost_full && w_push && !w_pop));

  assign {w_head_addr, w_head_data} = w_fifo_dout;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_din   ({wr_addr, wr_data}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

`ifdef SCREEN_FILL_PATTERN_EN
  logic [6:0] r_pat;
  logic [6:0] w_pat_next;

  assign w_pat_next = (r_pat == 7'(PRINT_SPAN - 1)) ? 7'd0 : r_pat + 7'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              r_pat <= '0;
    else if (r_state == IDLE && clr_start)    r_pat <= '0;
    else if (r_state == CLEAR && !w_last)     r_pat <= w_pat_next;
  end

  assign w_fill_first = DATA_WIDTH'(PRINT_FIRST);
  assign w_fill_next  = DATA_WIDTH'(PRINT_FIRST + w_pat_next);
`else
  assign w_fill_first = FILL_CHAR;
  assign w_fill_next  = FILL_CHAR;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr_ready  <= 1'b0;
      r_clr_busy  <= 1'b0;
      r_clr_done  <= 1'b0;
      r_bad_addr  <= 1'b0;
      r_bram_wen  <= 1'b0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
    end else begin
      r_wr_ready <= w_ready_next;
      r_bad_addr <= w_accept && !w_in_range;
      r_clr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_state     <= CLEAR;
            r_cnt       <= '0;
            r_clr_busy  <= 1'b1;
            r_bram_wen  <= 1'b1;
            r_bram_addr <= '0;
            r_bram_data <= w_fill_first;
          end else if (!w_fifo_empty) begin
            r_bram_wen  <= 1'b1;
            r_bram_addr <= w_head_addr;
            r_bram_data <= w_head_data;
          end else begin
            r_bram_wen  <= 1'b0;
          end
        end
        CLEAR: begin
          if (w_last) begin
            r_state    <= IDLE;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
            r_bram_wen <= 1'b0;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_bram_wen  <= 1'b1;
            r_bram_addr <= r_cnt + 1'b1;
            r_bram_data <= w_fill_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_ready  = r_wr_ready;
  assign clr_busy  = r_clr_busy;
  assign clr_done  = r_clr_done;
  assign bad_addr  = r_bad_addr;
  assign bram_wen  = r_bram_wen;
  assign bram_addr = r_bram_addr;
  assign bram_data = r_bram_data;
endmodule

// File: doc/screen_write_sched.md
Name: screen_write_sched

Overview:
- Write-side scheduler for the character screen BRAM port A, which is shared between UART character writes and a full-screen clear engine.
- Buffers incoming character writes in a small FIFO and sequences a clear/fill sweep over every slot.
- Arbitrates the two sources so that each cycle issues at most one BRAM write.
- Sits between uart2bram and the screen block_ram write port. Runs in the pixel clock domain.

Parameters:
- SCREEN_ADDRESS_WIDTH, 15, width of the screen BRAM address.
- SLOT_COUNT, 32400, number of valid character slots (horizontal x vertical, 240x135).
- DATA_WIDTH, 7, character code width.
- FIFO_DEPTH, 4, write FIFO entries; must be a power of 2 and at least 2.
- FILL_CHAR, 7'h20, code written by the clear engine.

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- wr_valid  in  1  character write request.
- wr_ready  out  1  FIFO can accept a write.
- wr_addr  in  SCREEN_ADDRESS_WIDTH  target slot.
- wr_data  in  DATA_WIDTH  character code.
- clr_start  in  1  single-cycle pulse that requests a full-screen clear.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  single-cycle pulse when the sweep completes.
- bad_addr  out  1  single-cycle pulse when a write with wr_addr >= SLOT_COUNT is discarded.
- bram_wen  out  1  BRAM port A write enable.
- bram_addr  out  SCREEN_ADDRESS_WIDTH  BRAM port A address.
- bram_data  out  DATA_WIDTH  BRAM port A data.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low; clock port is clk and reset port is resetn.
- Reset values: all outputs are registered and clear to 0 on reset, except wr_ready, which reads 1 from the first clock after reset. Reset also empties the FIFO and sets the FSM to IDLE.
- Handshake:
  - A write is accepted when wr_valid && wr_ready at a rising edge.
  - wr_ready = !fifo_full. There is no same-cycle pass-through when full, even if a pop occurs that cycle.
  - The producer holds wr_addr and wr_data while wr_valid && !wr_ready.
- Address check: an accepted write with wr_addr >= SLOT_COUNT is not pushed into the FIFO; bad_addr pulses on the next cycle.
- FSM states: IDLE and CLEAR.
  - IDLE: if clr_start, go to CLEAR with the clear counter at 0. Otherwise, if the FIFO is non-empty, pop the head and issue the BRAM write on the next cycle.
  - CLEAR: issue one write per cycle at address cnt with FILL_CHAR; the FIFO is never popped.
  - After the write at cnt = SLOT_COUNT-1, return to IDLE. clr_done pulses in the cycle the FSM is first back in IDLE.
  - clr_busy is high for exactly SLOT_COUNT cycles.
- Priority:
  - clr_start in IDLE beats a pending FIFO entry in the same cycle.
  - Writes accepted during CLEAR are held and drained after the sweep, so later characters survive the clear.
  - clr_start while busy is ignored; no restart and no queueing.
- Latency: a write accepted into an empty FIFO in IDLE produces bram_wen exactly 2 cycles after acceptance (push, pop, output register). After that, FIFO drain runs at one write per cycle.
- Widths: the clear counter is SCREEN_ADDRESS_WIDTH bits and compares against SLOT_COUNT-1, never the all-ones value.
- Reset mid-operation: a reset mid-sweep aborts the clear, discards any pending writes, and deasserts bram_wen immediately (asynchronously).

Optional Feature:
- Macro: SCREEN_FILL_PATTERN_EN.
- When defined, the clear engine writes a bring-up pattern instead of FILL_CHAR: data = 7'h20 + (cnt mod 95), i.e. printable ASCII cycling 0x20..0x7E. This is generated by a wrapping mod-95 counter that advances alongside cnt, not by a divider.
- When undefined, every slot receives FILL_CHAR and the pattern counter is absent.

Decomposition:
- Shared package screen_pkg holds:
  - SCREEN_ADDRESS_WIDTH, SLOT_COUNT and DATA_WIDTH defaults;
  - the ASCII constants SPACE=7'h20, PRINT_FIRST=7'h20, PRINT_SPAN=95;
  - the FSM state enum (IDLE, CLEAR).
- One sub-module: sync_fifo (parameterised width and depth; push, pop, full, empty, dout). It is instantiated once for the concatenated {addr,data}.

Test Plan:
- Reset then a single write (addr 5, data 0x41): bram_wen=1 with addr 5, data 0x41 exactly 2 cycles after the handshake; no other writes follow.
- clr_start pulse in IDLE: 32400 consecutive writes at addresses 0..32399 with data 0x20; clr_busy is high 32400 cycles; one clr_done pulse; address 32400 is never written.
- 6 back-to-back writes issued during CLEAR: the first 4 are accepted; wr_ready=0 until the sweep ends; all 6 appear in order after clr_done with no losses.
- Write with addr 32400: bad_addr pulses once; bram_wen stays 0; a following valid write (addr 0) is written normally.
- resetn asserted at sweep address 1000 with 2 FIFO entries pending: all outputs go to 0 asynchronously; no writes after release until new requests arrive.
- With SCREEN_FILL_PATTERN_EN: the sweep writes 0x20 at addr 0, 0x7E at addr 94, 0x20 at addr 95, and 0x21 at addr 96.
